// File: rtl/etapa_entradas_alu.sv
// ALU input stage: operands and op code queued in a small FWFT FIFO
// with valid/ready on both sides and a synchronous flush.
module etapa_entradas_alu #(
  parameter int WIDTH    = 8,
  parameter int OP_WIDTH = 3,
  parameter int DEPTH    = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       flush,
  input  logic [WIDTH-1:0]           entrada1,
  input  logic [WIDTH-1:0]           entrada2,
  input  logic [OP_WIDTH-1:0]        selector,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic [WIDTH-1:0]           salida1,
  output logic [WIDTH-1:0]           salida2,
  output logic [OP_WIDTH-1:0]        salida_selector,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [$clog2(DEPTH):0]     nivel
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0]    mem_a_q [DEPTH];
  logic [WIDTH-1:0]    mem_b_q [DEPTH];
  logic [OP_WIDTH-1:0] mem_s_q [DEPTH];

  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LW-1:0] nivel_q, nivel_d;

  logic push, pop;

  assign in_ready  = (nivel_q != LW'(DEPTH));
  assign out_valid = (nivel_q != '0);
  assign nivel     = nivel_q;

  assign push = in_valid && in_ready;
  assign pop  = out_valid && out_ready;

  // Head is forced to zero while empty; no bypass from the input.
  assign salida1         = out_valid ? mem_a_q[rd_ptr_q] : '0;
  assign salida2         = out_valid ? mem_b_q[rd_ptr_q] : '0;
  assign salida_selector = out_valid ? mem_s_q[rd_ptr_q] : '0;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    nivel_d  = nivel_q;
    if (flush) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      nivel_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   nivel_d = nivel_q + LW'(1);
        2'b01:   nivel_d = nivel_q - LW'(1);
        default: nivel_d = nivel_q;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      nivel_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      nivel_q  <= nivel_d;
    end
  end

  // Payload storage needs no reset; only entries below nivel are visible.
  always_ff @(posedge clock) begin
    if (push && !flush) begin
      mem_a_q[wr_ptr_q] <= entrada1;
      mem_b_q[wr_ptr_q] <= entrada2;
      mem_s_q[wr_ptr_q] <= selector;
    end
  end

endmodule

// File: tb/tb_etapa_entradas_alu.sv
// Directed bench for etapa_entradas_alu: reset, back-pressure,
// streaming, flush and a randomly stalled wrap-around run.
module tb_etapa_entradas_alu;

  localparam int W  = 16;
  localparam int OW = 4;
  localparam int D  = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          flush;
  logic [W-1:0]  entrada1, entrada2;
  logic [OW-1:0] selector;
  logic          in_valid, in_ready;
  logic [W-1:0]  salida1, salida2;
  logic [OW-1:0] salida_selector;
  logic          out_valid, out_ready;
  logic [2:0]    nivel;

  int nerr = 0;
  int nchk = 0;

  etapa_entradas_alu #(.WIDTH(W), .OP_WIDTH(OW), .DEPTH(D)) dut (
    .clock(clock), .reset(reset), .flush(flush),
    .entrada1(entrada1), .entrada2(entrada2), .selector(selector),
    .in_valid(in_valid), .in_ready(in_ready),
    .salida1(salida1), .salida2(salida2),
    .salida_selector(salida_selector),
    .out_valid(out_valid), .out_ready(out_ready), .nivel(nivel)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [OW-1:0] s);
    entrada1 = a;
    entrada2 = b;
    selector = s;
  endtask

  task automatic head(input string tag, input logic [W-1:0] a,
                      input logic [W-1:0] b, input logic [OW-1:0] s);
    chk(tag, {salida1, salida2, salida_selector}, {a, b, s});
  endtask

  logic [35:0] q[$];
  logic [35:0] expv;
  logic        p, o;
  int          sent, got, cyc;

  initial begin
    reset = 1'b1; flush = 1'b0;
    in_valid = 1'b0; out_ready = 1'b0;
    drive('0, '0, '0);
    #2;
    chk("rst_nivel", nivel, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_salida1", salida1, 0);
    tick(); tick();
    reset = 1'b0;

    // reset mid-stream
    in_valid = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      drive(W'(i), W'(i + 16), OW'(i));
      tick();
    end
    in_valid = 1'b0;
    chk("mid_nivel3", nivel, 3);
    #2 reset = 1'b1;
    #1;
    chk("mid_rst_nivel", nivel, 0);
    chk("mid_rst_out_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    head("mid_rst_outs", 0, 0, 0);
    #1 reset = 1'b0;
    drive(16'h12, 16'h34, 4'd3);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("post_rst_valid", out_valid, 1);
    chk("post_rst_nivel", nivel, 1);
    head("post_rst_head", 16'h12, 16'h34, 4'd3);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("post_rst_empty", nivel, 0);
    head("post_rst_zero", 0, 0, 0);

    // fill and back-pressure
    in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      drive(W'(16'hA0 + k), W'(16'hB0 + k), OW'(k));
      tick();
    end
    chk("full_nivel", nivel, 4);
    chk("full_in_ready", in_ready, 0);
    drive(16'hA5, 16'hB5, 4'd5);
    tick();
    chk("full_hold_nivel", nivel, 4);
    head("full_head_a1", 16'hA1, 16'hB1, 4'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("full_pop_nivel", nivel, 3);
    chk("full_pop_ready", in_ready, 1);
    tick();
    in_valid = 1'b0;
    chk("full_a5_nivel", nivel, 4);
    out_ready = 1'b1;
    for (int k = 2; k <= 5; k++) begin
      head("drain", W'(16'hA0 + k), W'(16'hB0 + k), OW'(k));
      tick();
    end
    out_ready = 1'b0;
    chk("drain_nivel", nivel, 0);

    // full-rate streaming
    in_valid = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      drive(W'(i), W'(i + 256), OW'(i % 16));
      tick();
      chk("stream_nivel", nivel, 1);
      head("stream_head", W'(i), W'(i + 256), OW'(i % 16));
    end
    in_valid = 1'b0;
    tick();
    out_ready = 1'b0;
    chk("stream_end", nivel, 0);

    // simultaneous push/pop at nivel=2
    in_valid = 1'b1;
    drive(16'hC1, 16'hD1, 4'd1); tick();
    drive(16'hC2, 16'hD2, 4'd2); tick();
    chk("pp_nivel2", nivel, 2);
    drive(16'hC3, 16'hD3, 4'd3);
    out_ready = 1'b1;
    tick();
    in_valid = 1'b0;
    chk("pp_nivel_kept", nivel, 2);
    head("pp_head_c2", 16'hC2, 16'hD2, 4'd2);
    tick();
    head("pp_tail_c3", 16'hC3, 16'hD3, 4'd3);
    chk("pp_nivel1", nivel, 1);
    tick();
    out_ready = 1'b0;
    chk("pp_empty", nivel, 0);

    // flush with concurrent push and pop at nivel=3
    in_valid = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      drive(W'(16'hE0 + k), W'(16'hF0 + k), OW'(k));
      tick();
    end
    chk("fl_nivel3", nivel, 3);
    drive(16'hE4, 16'hF4, 4'd4);
    out_ready = 1'b1;
    flush = 1'b1;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    chk("fl_nivel", nivel, 0);
    chk("fl_out_valid", out_valid, 0);
    chk("fl_in_ready", in_ready, 1);
    head("fl_outs", 0, 0, 0);
    tick();
    chk("fl_no_push", nivel, 0);
    drive(16'h77, 16'h88, 4'd9);
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    head("fl_next_head", 16'h77, 16'h88, 4'd9);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // wrap-around with random stalls
    sent = 0; got = 0; cyc = 0;
    drive(W'($urandom), W'($urandom), OW'($urandom));
    while (got < 2 * D + 1 && cyc < 300) begin
      in_valid  = (sent < 2 * D + 1);
      out_ready = 1'($urandom_range(0, 1));
      #3;
      chk("wr_nivel", nivel, q.size());
      chk("wr_in_ready", in_ready, q.size() != D);
      chk("wr_out_valid", out_valid, q.size() != 0);
      p = in_valid && (q.size() != D);
      o = out_ready && (q.size() != 0);
      if (o) begin
        expv = q.pop_front();
        chk("wr_data", {salida1, salida2, salida_selector}, expv);
        got++;
      end
      if (p) begin
        q.push_back({entrada1, entrada2, selector});
        sent++;
      end
      tick();
      if (p) drive(W'($urandom), W'($urandom), OW'($urandom));
      cyc++;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("wr_done", got, 2 * D + 1);
    chk("wr_final_nivel", nivel, 0);

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
